// File: rtl/register_file.sv
// register_file: flip-flop register file with one synchronous write port and two combinational read ports.
module register_file #(
  parameter int N        = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_ena,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [N-1:0]      wr_data,
  input  logic [ADDR_W-1:0] rd_addr0,
  output logic [N-1:0]      rd_data0,
  input  logic [ADDR_W-1:0] rd_addr1,
  output logic [N-1:0]      rd_data1
);
  localparam int R = 2**ADDR_W;
  logic [N-1:0]      regs [R];
  logic [N-1:0]      tree [2][2*R-1];
  logic [ADDR_W-1:0] addr [2];
  assign addr[0] = rd_addr0;
  assign addr[1] = rd_addr1;
  for (genvar i = 0; i < R; i++) begin : g_reg
    if (ZERO_REG && i == 0) begin : g_zero
      assign regs[i] = '0;
    end else begin : g_ff
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) regs[i] <= '0;
        else if (wr_ena && wr_addr == ADDR_W'(i)) regs[i] <= wr_data;
    end
  end
  // Heap-ordered mux tree: node j has children 2j+1/2j+2, leaves at R-1..2R-2;
  // the root selects on the MSB and the level just above the leaves on the LSB.
  for (genvar p = 0; p < 2; p++) begin : g_port
    for (genvar j = 0; j < R; j++) begin : g_leaf
      assign tree[p][R-1+j] = regs[j];
    end
    for (genvar j = 0; j < R-1; j++) begin : g_node
      assign tree[p][j] = addr[p][ADDR_W-$clog2(j+2)] ? tree[p][2*j+2] : tree[p][2*j+1];
    end
  end
  assign rd_data0 = tree[0][0];
  assign rd_data1 = tree[1][0];
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed vector table plus hand-written reset, sweep and parameter sequences.
module tb_register_file;
  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] e0;
    logic [31:0] e1;
  } vec_t;
  logic        clk = 0, rst_n = 0, wr_ena = 0;
  logic [4:0]  wr_addr = 0, rd_addr0 = 0, rd_addr1 = 0;
  logic [31:0] wr_data = 0, rd_data0, rd_data1, z_data0, z_data1;
  logic        s_ena = 0;
  logic [2:0]  s_wa = 0, s_ra0 = 0, s_ra1 = 0;
  logic [7:0]  s_wd = 0, s_rd0, s_rd1;
  int checks = 0, failures = 0;
  vec_t v[15];

  register_file dut (.clk(clk), .rst_n(rst_n), .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr0(rd_addr0), .rd_data0(rd_data0), .rd_addr1(rd_addr1), .rd_data1(rd_data1));
  register_file #(.ZERO_REG(0)) dut_nz (.clk(clk), .rst_n(rst_n), .wr_ena(wr_ena), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr0(rd_addr0), .rd_data0(z_data0), .rd_addr1(rd_addr1), .rd_data1(z_data1));
  register_file #(.N(8), .ADDR_W(3)) dut_s (.clk(clk), .rst_n(rst_n), .wr_ena(s_ena), .wr_addr(s_wa),
    .wr_data(s_wd), .rd_addr0(s_ra0), .rd_data0(s_rd0), .rd_addr1(s_ra1), .rd_data1(s_rd1));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    v[0]  = '{1'b1, 5'd3,  32'h0000_0033, 5'd3,  5'd3,  32'h0,          32'h0};
    v[1]  = '{1'b0, 5'd3,  32'h0000_0000, 5'd3,  5'd0,  32'h0000_0033, 32'h0};
    v[2]  = '{1'b1, 5'd0,  32'hFFFF_FFFF, 5'd0,  5'd3,  32'h0,          32'h0000_0033};
    v[3]  = '{1'b0, 5'd0,  32'h0000_0000, 5'd0,  5'd0,  32'h0,          32'h0};
    v[4]  = '{1'b1, 5'd7,  32'h1234_5678, 5'd7,  5'd7,  32'h0,          32'h0};
    v[5]  = '{1'b0, 5'd7,  32'hDEAD_BEEF, 5'd7,  5'd7,  32'h1234_5678, 32'h1234_5678};
    v[6]  = '{1'b0, 5'd7,  32'hDEAD_BEEF, 5'd7,  5'd3,  32'h1234_5678, 32'h0000_0033};
    v[7]  = '{1'b0, 5'd7,  32'hDEAD_BEEF, 5'd7,  5'd6,  32'h1234_5678, 32'h0};
    v[8]  = '{1'b0, 5'd7,  32'h0000_0000, 5'd7,  5'd7,  32'h1234_5678, 32'h1234_5678};
    v[9]  = '{1'b1, 5'd5,  32'h0000_0011, 5'd5,  5'd5,  32'h0,          32'h0};
    v[10] = '{1'b1, 5'd5,  32'h0000_0022, 5'd5,  5'd5,  32'h0000_0011, 32'h0000_0011};
    v[11] = '{1'b0, 5'd5,  32'h0000_0000, 5'd5,  5'd7,  32'h0000_0022, 32'h1234_5678};
    v[12] = '{1'b1, 5'd31, 32'hFFFF_FFFF, 5'd31, 5'd3,  32'h0,          32'h0000_0033};
    v[13] = '{1'b0, 5'd31, 32'h0000_0000, 5'd31, 5'd30, 32'hFFFF_FFFF, 32'h0};
    v[14] = '{1'b0, 5'd0,  32'h0000_0000, 5'd4,  5'd6,  32'h0,          32'h0};
    #1;
    chk("reset_rd0", rd_data0, 32'h0);
    chk("reset_rd1", rd_data1, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      wr_ena = v[i].we; wr_addr = v[i].wa; wr_data = v[i].wd;
      rd_addr0 = v[i].ra0; rd_addr1 = v[i].ra1;
      #1;
      chk($sformatf("vec%0d_rd0", i), rd_data0, v[i].e0);
      chk($sformatf("vec%0d_rd1", i), rd_data1, v[i].e1);
    end
    // ZERO_REG=0 instance kept the all-ones write to register 0
    rd_addr0 = 0; rd_addr1 = 0;
    #1;
    chk("nz_reg0_rd0", z_data0, 32'hFFFF_FFFF);
    chk("nz_reg0_rd1", z_data1, 32'hFFFF_FFFF);
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      wr_ena = 1; wr_addr = 5'(i); wr_data = 32'hA5A5_0000 + i;
    end
    @(negedge clk);
    wr_ena = 0;
    for (int i = 0; i < 32; i++) begin
      rd_addr0 = 5'(i); rd_addr1 = 5'(31 - i);
      #1;
      chk($sformatf("sweep_rd0_a%0d", i), rd_data0, i == 0 ? 32'h0 : 32'hA5A5_0000 + i);
      chk($sformatf("sweep_rd1_a%0d", 31 - i), rd_data1, i == 31 ? 32'h0 : 32'hA5A5_0000 + 31 - i);
      chk($sformatf("nz_sweep_a%0d", i), z_data0, i == 0 ? 32'hFFFF_FFFF : 32'hA5A5_0000 + i);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      s_ena = 1; s_wa = 3'(i); s_wd = 8'h10 + 8'(i);
    end
    @(negedge clk);
    s_ena = 0;
    for (int i = 0; i < 8; i++) begin
      s_ra0 = 3'(i); s_ra1 = 3'(7 - i);
      #1;
      chk($sformatf("small_rd0_a%0d", i), 32'(s_rd0), i == 0 ? 32'h0 : 32'h10 + i);
      chk($sformatf("small_rd1_a%0d", 7 - i), 32'(s_rd1), i == 7 ? 32'h0 : 32'h10 + 7 - i);
    end
    // asynchronous reset mid-cycle with a write held active throughout
    @(negedge clk);
    wr_ena = 1; wr_addr = 5'd9; wr_data = 32'hCAFE_F00D;
    rd_addr0 = 5'd9; rd_addr1 = 5'd9;
    #2 rst_n = 0;
    #1;
    chk("rst_async_rd0", rd_data0, 32'h0);
    chk("rst_async_small", 32'(s_rd0), 32'h0);
    for (int i = 0; i < 32; i++) begin
      rd_addr0 = 5'(i); rd_addr1 = 5'(31 - i);
      #1;
      chk($sformatf("rst_rd0_a%0d", i), rd_data0, 32'h0);
      chk($sformatf("rst_rd1_a%0d", 31 - i), rd_data1, 32'h0);
    end
    @(negedge clk);
    wr_ena = 0; rst_n = 1;
    rd_addr0 = 5'd9; rd_addr1 = 5'd7;
    #1;
    chk("post_rst_blocked_wr", rd_data0, 32'h0);
    chk("post_rst_reg7", rd_data1, 32'h0);
    chk("post_rst_nz_reg0", z_data0 | z_data1, 32'h0);
    @(negedge clk);
    wr_ena = 1; wr_addr = 5'd9; wr_data = 32'h0000_0099;
    @(negedge clk);
    wr_ena = 0;
    #1;
    chk("first_wr_after_rst", rd_data0, 32'h0000_0099);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/register_file.md
# register_file

Parametrised multi-port register file: 2**ADDR_W registers of N bits each, one synchronous write port and two independent combinational read ports. Each read port is a parametrised-width 2**ADDR_W:1 selection tree, the N-bit, arbitrary-depth generalisation of the team's single-bit 32:1 mux. Register 0 is hardwired to zero. The block is the architectural register storage for the single-cycle RV32I core; its defaults give 32 x 32-bit registers.

## Interface
- N, default 32: data width of every register and data port.
- ADDR_W, default 5: address width; the file holds 2**ADDR_W registers, indices 0..2**ADDR_W-1.
- ZERO_REG, default 1: 1 = register 0 reads as constant 0 and ignores writes; 0 = register 0 is an ordinary register.
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low; clears every register.
- wr_ena  input  1  write enable, sampled on the rising edge of clk.
- wr_addr  input  ADDR_W  write register index.
- wr_data  input  N  write data.
- rd_addr0  input  ADDR_W  read port 0 register index.
- rd_data0  output  N  read port 0 data, combinational.
- rd_addr1  input  ADDR_W  read port 1 register index.
- rd_data1  output  N  read port 1 data, combinational.

## Operation
- Storage: 2**ADDR_W registers, each N bits, all flip-flops. No memory macros.
- Reset: while rst_n = 0, every register is 0 and writes are blocked. Reset takes effect immediately, independent of clk. Both rd_data outputs therefore read 0 for any address during reset.
- Write: on the rising edge of clk with rst_n = 1 and wr_ena = 1, register[wr_addr] <= wr_data. With wr_ena = 0, no register changes.
- Only the one addressed register updates. All other registers hold their values.
- ZERO_REG = 1:
  - A write to address 0 is discarded, including while wr_ena = 1.
  - Reading address 0 returns 0 on both ports.
- Read: rd_dataK = register[rd_addrK], a purely combinational function of rd_addrK and the stored state. There is no read enable.
- The two read ports are fully independent. Both may address the same register, and both return identical data.
- Read during write (rd_addrK = wr_addr, wr_ena = 1): before the edge, rd_dataK shows the old value. After the edge, it shows wr_data. There is no write-to-read bypass.
- Widths: wr_addr and rd_addr use all ADDR_W bits, so every address maps to a register and there is no out-of-range case. wr_data is stored unmodified, with no extension or truncation.
- Read tree: built as a parametrised binary mux tree of ADDR_W levels.
  - Level k is selected by rd_addr[k].
  - The LSB selects at the leaves; the MSB selects at the root.

## Timing
- Write latency: 1 cycle. Data on wr_data at edge T is visible on a matching read port after edge T, within the combinational settle time.
- Read latency: 0 cycles, combinational from rd_addrK and the register state.
- Reset assertion: all outputs go to 0 asynchronously.
- Reset deassertion: the first write can occur on the first rising edge of clk after rst_n rises. The environment guarantees rst_n deasserts away from a clk edge.
- Reset mid-operation: a write pending on the same edge as rst_n falling is lost, and the register reads 0.
- Simultaneous events: a write plus two reads of the same address in one cycle is legal. Both ports return the old value until the edge.
- Output reset values: rd_data0 = 0, rd_data1 = 0.

## Test plan
- Reset: preload registers 1..31 with nonzero values, then assert rst_n = 0 mid-cycle. Required: rd_data0 = rd_data1 = 0 immediately, for every address swept on both ports.
- Write/readback: write 32'hA5A5_0000 + i to register i for i = 1..31, then sweep rd_addr0 ascending and rd_addr1 descending. Required: each port returns 32'hA5A5_0000 + addr, and address 0 returns 0.
- Zero register: wr_ena = 1, wr_addr = 0, wr_data = 32'hFFFF_FFFF. Required: rd_data0 for address 0 stays 0. Repeat with ZERO_REG = 0: required readback is 32'hFFFF_FFFF.
- Write enable low: with register 7 = 32'h1234_5678, apply wr_ena = 0, wr_addr = 7, wr_data = 32'hDEAD_BEEF for 3 edges. Required: register 7 still reads 32'h1234_5678.
- Read during write: register 5 = 32'h0000_0011, rd_addr0 = rd_addr1 = 5, write 32'h0000_0022 to register 5. Required: both ports show 11 before the edge and 22 after it, with no other register changed.
- Parameter sweep: instantiate N = 8 and ADDR_W = 3. Write 8'h10 + i to each register, then read back 8'h10 + i on both ports. Required: register 0 reads 0, and no aliasing between addresses.
